// File: rtl/bus_xfer_pkg.sv
// ============================================================================
// bus_xfer_pkg -- command op encodings and sequencer states for bus_xfer_engine
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_xfer_pkg;

    localparam logic [1:0] OP_MOVE  = 2'd0;
    localparam logic [1:0] OP_LOADI = 2'd1;
    localparam logic [1:0] OP_MEMRD = 2'd2;
    localparam logic [1:0] OP_MEMWR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XFER = 3'd1,
        ST_MAR  = 3'd2,
        ST_MDRW = 3'd3,
        ST_WAIT = 3'd4,
        ST_WB   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_regfile.sv
// ============================================================================
// bus_regfile -- NREGS x DATA_W register file, R0 reads as zero,
// one synchronous write port and two combinational read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [SEL_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [SEL_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [SEL_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam logic [SEL_W:0] NREGS_LIM = (SEL_W+1)'(NREGS);

    logic [DATA_W-1:0] regs [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0) && ({1'b0, waddr} < NREGS_LIM)) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_reg(input logic [SEL_W-1:0] sel);
        if ((sel == '0) || ({1'b0, sel} >= NREGS_LIM)) return '0;
        return regs[sel];
    endfunction

    assign rdata_a = read_reg(raddr_a);
    assign rdata_b = read_reg(raddr_b);

endmodule

`default_nettype wire

// File: rtl/bus_xfer_engine.sv
// ============================================================================
// bus_xfer_engine -- single-bus register-transfer sequencer with MAR/MDR and
// req/ack memory port. Optional WAIT timeout: define MEM_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_xfer_engine
    import bus_xfer_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NREGS          = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int SEL_W         = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_src,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] bus_out,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [SEL_W:0] NREGS_LIM = (SEL_W+1)'(NREGS);

    state_t            state, state_next;
    logic [1:0]        lat_op;
    logic [SEL_W-1:0]  lat_src, lat_dst, rf_raddr;
    logic [DATA_W-1:0] lat_imm, mar, mdr, bus, rf_rdata;
    logic              lat_err, accept, bad_sel, rf_we, timeout;

    assign accept   = (state == ST_IDLE) && cmd_valid;
    assign bad_sel  = ({1'b0, cmd_src} >= NREGS_LIM) || ({1'b0, cmd_dst} >= NREGS_LIM);
    // MEMWR reuses the dst select as its data register during MDRW.
    assign rf_raddr = (state == ST_MDRW) ? lat_dst : lat_src;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                               wait_cnt <= '0;
        else if ((state == ST_WAIT) && !mem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
        else                                   wait_cnt <= '0;
    end

    // An ack in the last counted cycle suppresses the timeout.
    assign timeout = (state == ST_WAIT) && !mem_ack && (wait_cnt == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus        = '0;
        rf_we      = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (bad_sel)                                      state_next = ST_DONE;
                    else if ((cmd_op == OP_MOVE) || (cmd_op == OP_LOADI)) state_next = ST_XFER;
                    else                                              state_next = ST_MAR;
                end
            end
            ST_XFER: begin
                bus        = (lat_op == OP_LOADI) ? lat_imm : rf_rdata;
                rf_we      = 1'b1;
                state_next = ST_DONE;
            end
            ST_MAR: begin
                bus        = rf_rdata;
                state_next = (lat_op == OP_MEMWR) ? ST_MDRW : ST_WAIT;
            end
            ST_MDRW: begin
                bus        = rf_rdata;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                mem_we  = (lat_op == OP_MEMWR);
                if (mem_ack)      state_next = (lat_op == OP_MEMRD) ? ST_WB : ST_DONE;
                else if (timeout) state_next = ST_DONE;
            end
            ST_WB: begin
                bus        = mdr;
                rf_we      = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = lat_err;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lat_op  <= OP_MOVE;
            lat_src <= '0;
            lat_dst <= '0;
            lat_imm <= '0;
            lat_err <= 1'b0;
            mar     <= '0;
            mdr     <= '0;
        end else begin
            if (accept) begin
                lat_op  <= cmd_op;
                lat_src <= cmd_src;
                lat_dst <= cmd_dst;
                lat_imm <= cmd_imm;
                lat_err <= bad_sel;
            end
            if (state == ST_MAR)  mar <= bus;
            if (state == ST_MDRW) mdr <= bus;
            if ((state == ST_WAIT) && mem_ack && (lat_op == OP_MEMRD)) mdr <= mem_rdata;
            if (timeout) lat_err <= 1'b1;
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign bus_out   = bus;

    bus_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .clr     (clr),
        .we      (rf_we),
        .waddr   (lat_dst),
        .wdata   (bus),
        .raddr_a (rf_raddr),
        .rdata_a (rf_rdata),
        .raddr_b (rd_sel),
        .rdata_b (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_engine.sv
// ============================================================================
// tb_bus_xfer_engine -- table-driven bench with response scoreboard and a
// register-file reference model for bus_xfer_engine (NREGS=12)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_xfer_engine;
    import bus_xfer_pkg::*;

    localparam int NR = 12;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_src, cmd_dst, rd_sel;
    logic [31:0]   cmd_imm, mem_addr, mem_wdata, mem_rdata, bus_out, rd_data;
    logic          rsp_valid, rsp_err, mem_req, mem_we, mem_ack;

    bus_xfer_engine #(.DATA_W(32), .NREGS(NR), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_out(bus_out), .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [SW-1:0] src;
        logic [SW-1:0] dst;
        logic [31:0]   imm;
        int            dly;    // non-acked WAIT cycles before the ack cycle
        logic [31:0]   rdata;
        logic          err;
        int            lat;    // accept edge to rsp_valid cycle
    } vec_t;

    typedef struct {
        logic err;
        int   acc;
        int   lat;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          errors = 0, checks = 0, cyc = 0, rsp_count = 0;
    logic [31:0] model [NR];
    vec_t        tbl [13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                chk("rsp_latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
    end

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            rd_sel = SW'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), rd_data, model[i]);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [SW-1:0] src, input logic [SW-1:0] dst,
                         input logic [31:0] imm, output int acc);
        @(posedge clk); #1;
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm; cmd_valid = 1'b1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_mem_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("rsp_outstanding", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int          acc, n;
        sb_t         e;
        logic [31:0] exp_addr, exp_wdata;
        exp_addr  = v.err ? 32'd0 : model[v.src];
        exp_wdata = v.err ? 32'd0 : model[v.dst];
        issue(v.op, v.src, v.dst, v.imm, acc);
        e.err = v.err; e.acc = acc; e.lat = v.lat;
        sb.push_back(e);
        if (!v.err && (v.op == OP_MOVE || v.op == OP_LOADI)) begin
            @(negedge clk);
            chk("xfer_bus", bus_out, (v.op == OP_LOADI) ? v.imm : exp_addr);
        end else if (!v.err) begin
            wait_mem_req(n);
            chk("wait_entry", n, (v.op == OP_MEMRD) ? 2 : 3);
            for (int i = 0; i <= v.dly; i++) begin
                chk("mem_req", {31'd0, mem_req}, 32'd1);
                chk("mem_we", {31'd0, mem_we}, (v.op == OP_MEMWR) ? 32'd1 : 32'd0);
                chk("mem_addr", mem_addr, exp_addr);
                chk("wait_bus", bus_out, 32'd0);
                if (v.op == OP_MEMWR) chk("mem_wdata", mem_wdata, exp_wdata);
                if (i == v.dly) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = '0;
                end else begin
                    @(negedge clk);
                end
            end
        end
        wait_drain();
        if (!v.err && v.dst != 0) begin
            case (v.op)
                OP_LOADI: model[v.dst] = v.imm;
                OP_MOVE:  model[v.dst] = model[v.src];
                OP_MEMRD: model[v.dst] = v.rdata;
                default:  ;
            endcase
        end
        check_regs("regs");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   acc, n, base;
        sb_t  e;
        cmd_valid = 1'b0; cmd_op = OP_MOVE; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        mem_ack = 1'b0; mem_rdata = '0; rd_sel = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        tbl[0]  = '{OP_LOADI, 4'd0,  4'd3,  32'hDEADBEEF, 0, 32'h0,        1'b0, 2};
        tbl[1]  = '{OP_MOVE,  4'd3,  4'd0,  32'h0,        0, 32'h0,        1'b0, 2};
        tbl[2]  = '{OP_MOVE,  4'd3,  4'd5,  32'h0,        0, 32'h0,        1'b0, 2};
        tbl[3]  = '{OP_LOADI, 4'd0,  4'd4,  32'h00000100, 0, 32'h0,        1'b0, 2};
        tbl[4]  = '{OP_MEMRD, 4'd4,  4'd6,  32'h0,        3, 32'h12345678, 1'b0, 7};
        tbl[5]  = '{OP_MEMWR, 4'd4,  4'd6,  32'h0,        0, 32'h0,        1'b0, 4};
        tbl[6]  = '{OP_MOVE,  4'd13, 4'd7,  32'h0,        0, 32'h0,        1'b1, 1};
        tbl[7]  = '{OP_LOADI, 4'd0,  4'd11, 32'hA5A50F0F, 0, 32'h0,        1'b0, 2};
        tbl[8]  = '{OP_MEMRD, 4'd11, 4'd0,  32'h0,        0, 32'hFFFFFFFF, 1'b0, 4};
        tbl[9]  = '{OP_LOADI, 4'd0,  4'd12, 32'h55555555, 0, 32'h0,        1'b1, 1};
        tbl[10] = '{OP_MEMWR, 4'd3,  4'd15, 32'h0,        0, 32'h0,        1'b1, 1};
        tbl[11] = '{OP_MOVE,  4'd11, 4'd1,  32'h0,        0, 32'h0,        1'b0, 2};
        tbl[12] = '{OP_MEMWR, 4'd11, 4'd5,  32'h0,        2, 32'h0,        1'b0, 6};

        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_bus_out",   bus_out,   32'd0);
        check_regs("rst");

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

`ifdef MEM_TIMEOUT_EN
        // No ack: eight WAIT cycles, then an error response and no write.
        issue(OP_MEMRD, 4'd4, 4'd9, 32'h0, acc);
        e.err = 1'b1; e.acc = acc; e.lat = 10;
        sb.push_back(e);
        wait_mem_req(n);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, 8);
        wait_drain();
        check_regs("timeout");
`else
        // Without the timeout the engine waits indefinitely for the ack.
        v = '{OP_MEMRD, 4'd4, 4'd9, 32'h0, 20, 32'hCAFEF00D, 1'b0, 24};
        run_vec(v);
`endif

        // clr while waiting on memory: request drops at once, command is lost.
        issue(OP_MEMRD, 4'd4, 4'd7, 32'h0, acc);
        base = rsp_count;
        wait_mem_req(n);
        chk("clr_pre_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #3;
        clr = 1'b1;
        #1;
        chk("clr_mem_req",   {31'd0, mem_req},   32'd0);
        chk("clr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("clr_mem_we",    {31'd0, mem_we},    32'd0);
        chk("clr_mem_addr",  mem_addr, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (8) @(posedge clk);
        chk("clr_no_rsp", rsp_count, base);
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_regs("clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
